// File: rtl/chk_report_arb_if.sv
// Handshake bundle for chk_report_arb: requester side, shared report channel and counter.
// The arbiter connects as slave; the environment drives the master side.
interface chk_report_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic                      cfg_en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rpt_valid;
    logic                      rpt_ready;
    logic [ID_W-1:0]           rpt_id;
    logic [DATA_W-1:0]         rpt_data;
    logic [CNT_W-1:0]          rpt_count;

    modport master (
        output cfg_en, req_valid, req_data, rpt_ready,
        input  req_ready, rpt_valid, rpt_id, rpt_data, rpt_count
    );

    modport slave (
        input  cfg_en, req_valid, req_data, rpt_ready,
        output req_ready, rpt_valid, rpt_id, rpt_data, rpt_count
    );
endinterface

// File: rtl/chk_report_arb.sv
// Round-robin arbiter funnelling checker reports into one registered report channel,
// with a saturating count of completed transfers.
module chk_report_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic             clk,
    input logic             rst,
    chk_report_arb_if.slave bus
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rpt_id_q;
    logic [DATA_W-1:0]   rpt_data_q;
    logic [CNT_W-1:0]    rpt_count_q;

    logic [NUM_REQ-1:0]  rot_valid;
    logic [ID_W-1:0]     off;
    logic [ID_W:0]       sum;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W-1:0]     rr_ptr_next;
    logic                any_valid;
    logic                load;
    logic                xfer;

    // Rotate so bit 0 is the requester at rr_ptr; lowest set bit is the winner's offset.
    always_comb begin
        rot_valid = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
        any_valid = |bus.req_valid;
        off       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                off = ID_W'(i);
            end
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            gnt_idx = ID_W'(sum - (ID_W+1)'(NUM_REQ));
        end else begin
            gnt_idx = sum[ID_W-1:0];
        end
        if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = gnt_idx + 1'b1;
        end
    end

    // rst gates load so req_ready drops the instant reset asserts.
    assign load = !rst && bus.cfg_en && (state_q == StEmpty || bus.rpt_ready) && any_valid;
    assign xfer = (state_q == StFull) && bus.rpt_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (load) state_d = StFull;
            StFull:  if (bus.rpt_ready && !load) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            rr_ptr_q    <= '0;
            rpt_id_q    <= '0;
            rpt_data_q  <= '0;
            rpt_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                rr_ptr_q   <= rr_ptr_next;
                rpt_id_q   <= gnt_idx;
                rpt_data_q <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
            end
            if (xfer && rpt_count_q != {CNT_W{1'b1}}) begin
                rpt_count_q <= rpt_count_q + 1'b1;
            end
        end
    end

    assign bus.req_ready = load ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign bus.rpt_valid = (state_q == StFull);
    assign bus.rpt_id    = rpt_id_q;
    assign bus.rpt_data  = rpt_data_q;
    assign bus.rpt_count = rpt_count_q;
endmodule

// File: tb/tb_chk_report_arb.sv
// Directed and randomized bench for chk_report_arb against a queue-free round-robin model;
// a second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_chk_report_arb;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chk_report_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(16)) bus ();
    chk_report_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(2))  bus2 ();

    assign bus2.cfg_en    = bus.cfg_en;
    assign bus2.req_valid = bus.req_valid;
    assign bus2.req_data  = bus.req_data;
    assign bus2.rpt_ready = bus.rpt_ready;

    chk_report_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    chk_report_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the report channel holds, the pointer, and transfers so far.
    bit       m_held;
    int       m_id;
    int       m_data;
    int       m_ptr;
    int       m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held  = 1'b0;
        m_id    = 0;
        m_data  = 0;
        m_ptr   = 0;
        m_count = 0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int  g;
        int  idx;
        bit  ld;
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (g < 0 && bus.req_valid[idx]) g = idx;
        end
        ld      = bus.cfg_en && (!m_held || bus.rpt_ready) && (g >= 0);
        exp_rdy = ld ? NUM_REQ'(1 << g) : '0;
        chk("rpt_valid", 32'(bus.rpt_valid), 32'(m_held));
        if (m_held) begin
            chk("rpt_id", 32'(bus.rpt_id), 32'(m_id));
            chk("rpt_data", 32'(bus.rpt_data), 32'(m_data));
        end
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("rpt_count", 32'(bus.rpt_count), 32'(m_count));
        chk("rpt_count_sat", 32'(bus2.rpt_count), 32'((m_count > 3) ? 3 : m_count));
        @(posedge clk);
        if (m_held && bus.rpt_ready) m_count++;
        if (ld) begin
            m_held = 1'b1;
            m_id   = g;
            m_data = int'(bus.req_data[g*DATA_W +: DATA_W]);
            m_ptr  = (g + 1) % NUM_REQ;
        end else if (m_held && bus.rpt_ready) begin
            m_held = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        chk("rst_valid", 32'(bus.rpt_valid), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_count", 32'(bus.rpt_count), 32'd0);
        chk("rst_id", 32'(bus.rpt_id), 32'd0);
        chk("rst_data", 32'(bus.rpt_data), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic en, input logic [3:0] v, input logic rdy);
        bus.cfg_en    = en;
        bus.req_valid = v;
        bus.rpt_ready = rdy;
    endtask

    initial begin
        bus.cfg_en    = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rpt_ready = 1'b0;
        model_reset();
        #1;
        apply_reset();

        // All requesters, data 0xA+i, channel always ready: ids 0,1,2,3,0.
        bus.req_data = 16'hDCBA;
        drive(1'b1, 4'b1111, 1'b1);
        repeat (6) cycle();
        chk("seq_count", 32'(bus.rpt_count), 32'd5);
        chk("seq_count_sat", 32'(bus2.rpt_count), 32'd3);
        drive(1'b1, 4'b0000, 1'b1);
        repeat (3) cycle();
        chk("sat_hold", 32'(bus2.rpt_count), 32'd3);

        // Backpressure on a single held report.
        apply_reset();
        bus.req_data = 16'h0500;
        drive(1'b1, 4'b0100, 1'b0);
        cycle();
        repeat (3) cycle();
        chk("bp_id", 32'(bus.rpt_id), 32'd2);
        chk("bp_data", 32'(bus.rpt_data), 32'h5);
        drive(1'b1, 4'b0000, 1'b1);
        cycle();
        cycle();
        chk("bp_count", 32'(bus.rpt_count), 32'd1);

        // Pointer now at 3: requests on 0 and 3 grant 3 then 0.
        drive(1'b1, 4'b1001, 1'b1);
        bus.req_data = 16'h7001;
        cycle();
        chk("wrap_first", 32'(bus.rpt_id), 32'd3);
        cycle();
        chk("wrap_second", 32'(bus.rpt_id), 32'd0);

        // cfg_en drops while full: the held report drains, no new grants.
        drive(1'b0, 4'b1111, 1'b1);
        repeat (4) cycle();
        chk("dis_empty", 32'(bus.rpt_valid), 32'd0);

        // Reset while full and stalled, then first grant from index 0.
        drive(1'b1, 4'b0110, 1'b0);
        cycle();
        cycle();
        apply_reset();
        drive(1'b1, 4'b1111, 1'b1);
        cycle();
        chk("post_rst_id", 32'(bus.rpt_id), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bus.req_data  = 16'($urandom);
            bus.req_valid = 4'($urandom);
            bus.rpt_ready = ($urandom_range(0, 9) < 7);
            bus.cfg_en    = ($urandom_range(0, 9) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
